ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port external data memory (1-cycle registered read, byte-enable writes, `ready` handshake).
- Master 0 is the core LSU data port. Master 1 is the secondary master (DMA / PS2-ASCII loader).
- Round-robin grant, one transaction at a time.
- Drives the memory request through an access/response sequence, returns read data and a completion pulse to the winner, and aborts on a stalled memory `ready`.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive cycles with ready_i low in ACCESS/RESP before abort; 0 disables the timeout.
- ERR_DATA, 32'hdead_beef, read data returned on an aborted read.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  master 0 request; held until m0_ready_o
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  4  master 0 byte enables
- m0_addr_i  in  32  master 0 byte address
- m0_wdata_i  in  32  master 0 write data
- m0_rdata_o  out  32  master 0 read data, valid with m0_ready_o
- m0_ready_o  out  1  master 0 completion pulse
- m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ready_o  as master 0, for master 1
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- mem_ready_i  in  1  memory ready
- err_o  out  1  one-cycle pulse with the ready_o of an aborted transaction
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk_i. Reset is synchronous, active-high, on rst_i.
- States: IDLE, ACCESS, RESP, DONE.
- Reset values:
  - State = IDLE, last_grant = 1 (so master 0 wins the first tie).
  - Command and rdata registers = 0; timeout counter = 0.
  - All outputs 0.
  - Reset mid-transaction returns to IDLE at that edge with no completion pulse; a write already sampled by memory is not undone.
- IDLE:
  - If any req is high, pick the winner, latch its we/be/addr/wdata into command registers, record the grant, and go to ACCESS.
  - Arbitration: only one request high → that master wins. Both high → the master not equal to last_grant wins.
  - last_grant updates at grant time.
- ACCESS:
  - mem_req_o = 1, mem_we_o/be/addr/wdata from the command registers.
  - Read with mem_ready_i = 1 → go to RESP.
  - Write with mem_ready_i = 1 → go to DONE (write is committed at this edge).
  - mem_ready_i = 0 → stay in ACCESS and increment the timeout counter.
- RESP (reads only):
  - mem_req_o = 1, mem_we_o = 0, same address.
  - mem_ready_i = 1 → capture mem_rdata_i into the rdata register and go to DONE.
  - mem_ready_i = 0 → stay in RESP and increment the timeout counter.
- DONE:
  - The granted master's ready_o = 1 for exactly one cycle; mem_req_o = 0.
  - Next state is always IDLE.
  - Requests are not sampled in DONE; masters drop req in the cycle after ready_o.
- Timeout:
  - Counter clears on entry to ACCESS.
  - Counter reaching TIMEOUT_CYCLES while ready is low → go to DONE with err_o = 1.
  - Aborted read returns rdata = ERR_DATA; aborted write has rdata unchanged.
- mX_rdata_o:
  - Both ports show the rdata register, which holds its value until the next read completes.
  - Only the ready_o pulse qualifies the data.
- Nominal latency, with mem_ready_i tied high, from the first cycle req is seen in IDLE:
  - Read: ready_o in cycle +3.
  - Write: ready_o in cycle +2.
  - Back-to-back throughput: one read per 4 cycles, one write per 3 cycles.
- Requests arriving during ACCESS/RESP/DONE wait; there is no queuing beyond the req level.
- mem_* outputs are driven only from registers (no combinational path from mX_*_i to mem_*).
- The loser's input changes during a transaction have no effect.

Test Plan:
1. Single read: m0 reads addr 0x10 (memory word 0x12345678), ready tied 1 → mem_req_o high for 2 cycles with addr 0x10, we = 0; m0_ready_o pulses at cycle +3 with m0_rdata_o = 0x12345678; m1_ready_o stays 0.
2. Byte write then read: m1 writes 0xAABBCCDD with be = 4'b0101 to 0x20 (old 0x11223344), then reads 0x20 → m1_ready_o pulses at +2 then +3; read returns 0x11BB33DD.
3. Contention: m0 and m1 both request continuously for 4 transactions → grant order after reset is m0, m1, m0, m1; no cycle has both ready_o high.
4. Ready stall: during an m0 read, mem_ready_i is held 0 for 5 cycles in RESP → state stays RESP with addr stable; completes 5 cycles late with correct data and err_o = 0.
5. Timeout: TIMEOUT_CYCLES = 4, mem_ready_i stuck at 0 on an m1 read → m1_ready_o and err_o pulse together; m1_rdata_o = 0xdeadbeef; back in IDLE the next cycle.
6. Reset mid-op: rst_i asserted for 1 cycle while in RESP → next cycle busy_o = 0, mem_req_o = 0, no ready_o pulse; a new m0 request afterwards completes normally, with m0 winning the tie.

Source files
------------

// File: rtl/ext_mem_arbiter_if.sv
// ext_mem_arbiter_if: one request/response memory port.
//   req/we/be/addr/wdata : request side, driven by the requester
//   rdata/ready          : response side, driven by the responder
// Modports: master = requester view, slave = responder view.
interface ext_mem_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          req;
  logic          we;
  logic [BW-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output req, we, be, addr, wdata, input rdata, ready);
  modport slave  (input req, we, be, addr, wdata, output rdata, ready);
endinterface

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: two-master round-robin arbiter and sequencer in front of a
// single-port external data memory (1-cycle registered read, byte-enable
// writes, ready handshake). One transaction at a time; a stalled memory
// ready aborts the transaction after TIMEOUT_CYCLES (0 disables).
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   m0_if        : core LSU data port (slave view)
//   m1_if        : secondary master, DMA / loader (slave view)
//   mem_if       : external memory (master view)
//   err_o        : pulses with ready of an aborted transaction
//   busy_o       : high whenever the sequencer is not idle
module ext_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hdead_beef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ext_mem_arbiter_if.slave  m0_if,
  ext_mem_arbiter_if.slave  m1_if,
  ext_mem_arbiter_if.master mem_if,
  output logic              err_o,
  output logic              busy_o
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          cmd_we_q, cmd_we_d;
  logic [BW-1:0] cmd_be_q, cmd_be_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          pick;
  logic          timeout_hit;

  // Next state, command capture and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cmd_we_d     = cmd_we_q;
    cmd_be_d     = cmd_be_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    pick         = 1'b0;
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    case (state_q)
      S_IDLE: begin
        if (m0_if.req || m1_if.req) begin
          // On a tie the master that did not win last time goes first
          pick         = (m0_if.req && m1_if.req) ? ~last_grant_q : m1_if.req;
          gnt_d        = pick;
          last_grant_d = pick;
          cmd_we_d     = pick ? m1_if.we    : m0_if.we;
          cmd_be_d     = pick ? m1_if.be    : m0_if.be;
          cmd_addr_d   = pick ? m1_if.addr  : m0_if.addr;
          cmd_wdata_d  = pick ? m1_if.wdata : m0_if.wdata;
          cnt_d        = '0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS, S_RESP: begin
        if (mem_if.ready) begin
          cnt_d = '0;
          if (state_q == S_RESP) begin
            rdata_d = mem_if.rdata;
            state_d = S_DONE;
          end else begin
            state_d = cmd_we_q ? S_DONE : S_RESP;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          if (!cmd_we_q) rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so mem_* never sees a
    // combinational path from the master inputs
    mem_req_d  = (state_d == S_ACCESS) || (state_d == S_RESP);
    mem_we_d   = (state_d == S_ACCESS) && cmd_we_d;
    m0_ready_d = (state_d == S_DONE) && !gnt_d;
    m1_ready_d = (state_d == S_DONE) && gnt_d;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_be_q     <= '0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cmd_we_q     <= cmd_we_d;
      cmd_be_q     <= cmd_be_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_if.req   = mem_req_q;
  assign mem_if.we    = mem_we_q;
  assign mem_if.be    = cmd_be_q;
  assign mem_if.addr  = cmd_addr_q;
  assign mem_if.wdata = cmd_wdata_q;

  // Both masters see the shared read-data register; only ready qualifies it
  assign m0_if.rdata  = rdata_q;
  assign m0_if.ready  = m0_ready_q;
  assign m1_if.rdata  = rdata_q;
  assign m1_if.ready  = m1_ready_q;

  assign err_o  = err_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: a default instance on a behavioural memory plus
// a TIMEOUT_CYCLES=4 instance on a memory whose ready is stuck low.
module tb_ext_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err, err_to, busy, busy_to;
  logic mem_rdy = 1'b1;
  logic [31:0] mem_rd;
  logic [31:0] mem_arr [0:63];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          d;
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t q[$];

  ext_mem_arbiter_if m0();
  ext_mem_arbiter_if m1();
  ext_mem_arbiter_if mem();
  ext_mem_arbiter_if t0();
  ext_mem_arbiter_if t1();
  ext_mem_arbiter_if tmem();

  ext_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst), .m0_if(m0), .m1_if(m1), .mem_if(mem),
    .err_o(err), .busy_o(busy)
  );

  ext_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .m0_if(t0), .m1_if(t1), .mem_if(tmem),
    .err_o(err_to), .busy_o(busy_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: registered read, byte-enable write committed on ready
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
      mem_arr[4]  <= 32'h1234_5678;
      mem_arr[8]  <= 32'h1122_3344;
      mem_arr[12] <= 32'hcafe_f00d;
      mem_rd      <= 32'h0;
    end else if (mem.req) begin
      if (mem.we) begin
        if (mem_rdy)
          for (int b = 0; b < 4; b++)
            if (mem.be[b]) mem_arr[mem.addr[7:2]][8*b +: 8] <= mem.wdata[8*b +: 8];
      end else begin
        mem_rd <= mem_arr[mem.addr[7:2]];
      end
    end
  end
  assign mem.rdata  = mem_rd;
  assign mem.ready  = mem_rdy;
  assign tmem.rdata = 32'h0;
  assign tmem.ready = 1'b0;
  assign t0.req = 1'b0;
  assign t0.we = 1'b0;
  assign t0.be = 4'h0;
  assign t0.addr = 32'h0;
  assign t0.wdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int port, input logic [31:0] rd, input logic e, input int c);
    exp_t x;
    x.d = d; x.port = port; x.rdata = rd; x.err = e; x.cyc = c;
    q.push_back(x);
  endtask

  // Scoreboard monitor for one DUT
  task automatic sb(input int d, input logic r0, input logic r1,
                    input logic [31:0] rd0, input logic [31:0] rd1, input logic er);
    exp_t e;
    if (r0 === 1'b1 || r1 === 1'b1) begin
      chk("both_ready", 32'(r0 & r1), 32'h0);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ready: dut %0d ready %b%b with nothing expected", d, r1, r0);
      end else begin
        e = q.pop_front();
        chk("dut", 32'(d), 32'(e.d));
        chk("port", 32'(r1), 32'(e.port));
        chk("rdata", r1 ? rd1 : rd0, e.rdata);
        chk("err", 32'(er), 32'(e.err));
        chk("cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (er === 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL lone_err: dut %0d err without ready", d);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      sb(0, m0.ready, m1.ready, m0.rdata, m1.rdata, err);
      sb(1, t0.ready, t1.ready, t0.rdata, t1.rdata, err_to);
    end
  end

  // Drive one request on port p (0=m0, 1=m1, 2=timeout instance m1) and wait
  // for its ready; hold keeps req high for a following back-to-back request.
  task automatic drive(input int p, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    bit seen = 1'b0;
    case (p)
      0: begin m0.req = 1'b1; m0.we = we; m0.be = be; m0.addr = addr; m0.wdata = wdata; end
      1: begin m1.req = 1'b1; m1.we = we; m1.be = be; m1.addr = addr; m1.wdata = wdata; end
      default: begin t1.req = 1'b1; t1.we = we; t1.be = be; t1.addr = addr; t1.wdata = wdata; end
    endcase
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      case (p)
        0: seen = (m0.ready === 1'b1);
        1: seen = (m1.ready === 1'b1);
        default: seen = (t1.ready === 1'b1);
      endcase
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ready: port %0d got no ready expected one within 64 cycles", p);
    end
    @(posedge clk); #1;
    if (!hold) begin
      case (p)
        0: m0.req = 1'b0;
        1: m1.req = 1'b0;
        default: t1.req = 1'b0;
      endcase
    end
  endtask

  initial begin
    int c;
    m0.req = 1'b0; m0.we = 1'b0; m0.be = 4'h0; m0.addr = 32'h0; m0.wdata = 32'h0;
    m1.req = 1'b0; m1.we = 1'b0; m1.be = 4'h0; m1.addr = 32'h0; m1.wdata = 32'h0;
    t1.req = 1'b0; t1.we = 1'b0; t1.be = 4'h0; t1.addr = 32'h0; t1.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mem_req", 32'(mem.req), 32'h0);
    chk("rst_mem_we", 32'(mem.we), 32'h0);
    chk("rst_mem_be", 32'(mem.be), 32'h0);
    chk("rst_mem_addr", mem.addr, 32'h0);
    chk("rst_mem_wdata", mem.wdata, 32'h0);
    chk("rst_m0_ready", 32'(m0.ready), 32'h0);
    chk("rst_m1_ready", 32'(m1.ready), 32'h0);
    chk("rst_rdata", m0.rdata, 32'h0);
    chk("rst_busy_to", 32'(busy_to), 32'h0);
    @(posedge clk); #1;

    // 1: single read by m0, ready in cycle +3
    c = cyc;
    push(0, 0, 32'h1234_5678, 1'b0, c + 3);
    fork
      drive(0, 1'b0, 4'hf, 32'h10, 32'h0, 1'b0);
      begin
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          chk("t1_mem_req", 32'(mem.req), (k < 3) ? 32'h1 : 32'h0);
          if (k < 3) begin
            chk("t1_mem_addr", mem.addr, 32'h10);
            chk("t1_mem_we", 32'(mem.we), 32'h0);
          end
        end
      end
    join

    // 2: byte write by m1 (ready +2) then read back (ready +3)
    c = cyc;
    push(0, 1, 32'h1234_5678, 1'b0, c + 2);
    drive(1, 1'b1, 4'b0101, 32'h20, 32'haabb_ccdd, 1'b0);
    c = cyc;
    push(0, 1, 32'h11bb_33dd, 1'b0, c + 3);
    drive(1, 1'b0, 4'hf, 32'h20, 32'h0, 1'b0);

    // 3: contention, grant order m0, m1, m0, m1
    c = cyc;
    push(0, 0, 32'h1234_5678, 1'b0, c + 3);
    push(0, 1, 32'h11bb_33dd, 1'b0, c + 7);
    push(0, 0, 32'hcafe_f00d, 1'b0, c + 11);
    push(0, 1, 32'h1234_5678, 1'b0, c + 15);
    fork
      begin
        drive(0, 1'b0, 4'hf, 32'h10, 32'h0, 1'b1);
        drive(0, 1'b0, 4'hf, 32'h30, 32'h0, 1'b0);
      end
      begin
        drive(1, 1'b0, 4'hf, 32'h20, 32'h0, 1'b1);
        drive(1, 1'b0, 4'hf, 32'h10, 32'h0, 1'b0);
      end
    join

    // 4: ready stalled for 5 cycles in RESP, completes 5 cycles late
    c = cyc;
    push(0, 0, 32'h1234_5678, 1'b0, c + 8);
    fork
      drive(0, 1'b0, 4'hf, 32'h10, 32'h0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 mem_rdy = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_addr", mem.addr, 32'h10);
          chk("stall_req", 32'(mem.req), 32'h1);
          chk("stall_we", 32'(mem.we), 32'h0);
        end
        @(posedge clk);
        #1 mem_rdy = 1'b1;
      end
    join

    // 6: reset while in RESP, then a fresh tie goes to m0
    c = cyc;
    m0.req = 1'b1; m0.we = 1'b0; m0.be = 4'hf; m0.addr = 32'h10;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m0.req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_mem_req", 32'(mem.req), 32'h0);
    chk("rmid_m0_ready", 32'(m0.ready), 32'h0);
    chk("rmid_m1_ready", 32'(m1.ready), 32'h0);
    @(posedge clk); #1;
    c = cyc;
    push(0, 0, 32'h1234_5678, 1'b0, c + 3);
    push(0, 1, 32'h1122_3344, 1'b0, c + 7);
    fork
      drive(0, 1'b0, 4'hf, 32'h10, 32'h0, 1'b0);
      drive(1, 1'b0, 4'hf, 32'h20, 32'h0, 1'b0);
    join

    // 5: timeout on the TIMEOUT_CYCLES=4 instance, m1 read with ready stuck low
    c = cyc;
    push(1, 1, 32'hdead_beef, 1'b1, c + 5);
    drive(2, 1'b0, 4'hf, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
    chk("to_idle_busy", 32'(busy_to), 32'h0);
    chk("to_idle_req", 32'(tmem.req), 32'h0);
    chk("to_idle_err", 32'(err_to), 32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
